iseq_arbiter: RTL
=================

ISEQ_ARBITER -- requirements
Module: iseq_arbiter

Interface
REQ-001 SHALL have parameter MAX_PR_BURST, default 4: consecutive periodic-read grants allowed while host is pending.
REQ-002 SHALL have parameter PR_TIMEOUT, default 1023: maximum cycles in PR_LOCK before the timeout abort.
REQ-003 SHALL have parameter TO_WIDTH, default 10: width of the timeout counter; PR_TIMEOUT SHALL be < 2^TO_WIDTH.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 host_req  input  1  level; host has an instruction sequence loaded in the instr FIFOs.
REQ-007 host_ack  output  1  one-cycle pulse; host request accepted.
REQ-008 host_done  output  1  one-cycle pulse; host sequence fully dispatched.
REQ-009 pr_req  input  1  level; periodic-read engine requests the dispatcher.
REQ-010 pr_ack  output  1  one-cycle pulse; periodic read completed.
REQ-011 process_iseq  output  1  one-cycle start pulse to the dispatcher.
REQ-012 dispatcher_busy  input  1  dispatcher busy flag; registered, rises the cycle after process_iseq.
REQ-013 periodic_read_lock  output  1  level; grants the dispatcher to the periodic read.
REQ-014 pr_rd_ack  input  1  dispatcher pulse; periodic read issued.
REQ-015 pr_timeout  output  1  sticky error flag.
REQ-016 arb_state  output  3  current FSM state encoding, for debug.

Function
REQ-017 FSM states SHALL be IDLE=0, HOST_START=1, HOST_RUN=2, PR_LOCK=3.
REQ-018 IDLE arbitration:
- pr_req=1 and (host_req=0 or pr_streak<MAX_PR_BURST) -> PR_LOCK;
- else host_req=1 -> HOST_START;
- else stay in IDLE.
REQ-019 pr_streak SHALL:
- increment, saturating at MAX_PR_BURST, on each IDLE->PR_LOCK transition taken while host_req=1;
- clear on each IDLE->HOST_START transition.
REQ-020 HOST_START SHALL last exactly one cycle, assert process_iseq=1 and host_ack=1, then go to HOST_RUN.
REQ-021 HOST_RUN SHALL ignore dispatcher_busy on its first cycle. On any later cycle with dispatcher_busy=0 it SHALL pulse host_done for one cycle and return to IDLE.
REQ-022 PR_LOCK SHALL hold periodic_read_lock=1 and load the timeout counter with 0 on entry.
REQ-023 PR_LOCK exit on pr_rd_ack=1: pulse pr_ack for one cycle, deassert periodic_read_lock, go to IDLE.
REQ-024 PR_LOCK exit when the counter reaches PR_TIMEOUT without pr_rd_ack: set pr_timeout=1, go to IDLE, no pr_ack.
REQ-025 If pr_rd_ack and timeout occur in the same cycle, pr_rd_ack SHALL win: pr_ack is pulsed and pr_timeout is not set.
REQ-026 pr_rd_ack outside PR_LOCK SHALL be ignored.
REQ-027 pr_req deasserting during PR_LOCK SHALL NOT abort the lock.
REQ-028 host_req deasserting after host_ack SHALL NOT abort HOST_RUN.
REQ-029 process_iseq and periodic_read_lock SHALL never be 1 in the same cycle.
REQ-030 At most one grant SHALL be issued per IDLE visit; IDLE SHALL last at least one cycle between grants.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 rst_n=0 SHALL immediately force:
- state=IDLE;
- pr_streak=0, timeout counter=0;
- process_iseq, host_ack, host_done, pr_ack, periodic_read_lock, pr_timeout = 0;
- arb_state=0.
REQ-033 Reset asserted mid-HOST_RUN or mid-PR_LOCK SHALL abort without a done/ack pulse.
REQ-034 After rst_n rises, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-035 host_req=1, pr_req=0 -> process_iseq pulse 1 cycle later. Then hold dispatcher_busy=1 for 5 cycles, then 0 -> host_done 1 cycle later, arb_state returns to 0.
REQ-036 pr_req=1, pr_rd_ack pulsed 3 cycles after lock -> periodic_read_lock high exactly 4 cycles, pr_ack pulse, pr_timeout=0.
REQ-037 host_req=1 and pr_req=1 held continuously, MAX_PR_BURST=4 -> 4 PR grants, then 1 host grant, pattern repeats; process_iseq and periodic_read_lock never both 1.
REQ-038 pr_req=1, no pr_rd_ack, PR_TIMEOUT=15 -> lock drops after 16 cycles, pr_timeout=1 stays set, no pr_ack.
REQ-039 pr_rd_ack on the timeout cycle -> pr_ack=1, pr_timeout=0.
REQ-040 rst_n=0 for 1 cycle during PR_LOCK -> periodic_read_lock=0 immediately, state 0, no pr_ack.

Source files
------------

// File: rtl/iseq_arbiter.sv
// Arbitrates the instruction-sequence dispatcher between host sequences and the
// periodic-read engine, with a bounded periodic-read burst and a lock timeout.
module iseq_arbiter #(
  parameter int MAX_PR_BURST = 4,
  parameter int PR_TIMEOUT   = 1023,
  parameter int TO_WIDTH     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_req,
  output logic       host_ack,
  output logic       host_done,
  input  logic       pr_req,
  output logic       pr_ack,
  output logic       process_iseq,
  input  logic       dispatcher_busy,
  output logic       periodic_read_lock,
  input  logic       pr_rd_ack,
  output logic       pr_timeout,
  output logic [2:0] arb_state
);

  localparam int STREAK_W = (MAX_PR_BURST < 1) ? 1 : $clog2(MAX_PR_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_PR_BURST);
  localparam logic [TO_WIDTH-1:0] TO_LIMIT   = TO_WIDTH'(PR_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOST_START = 3'd1,
    HOST_RUN   = 3'd2,
    PR_LOCK    = 3'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                run_first_q, run_first_d;
  logic                armed_q;

  logic host_ack_d, host_done_d, pr_ack_d, process_iseq_d;
  logic lock_d, pr_timeout_d;

  // Outputs are computed from the next state so every one of them comes
  // straight off a flop yet lines up with the state it belongs to.
  always_comb begin
    state_d        = state_q;
    streak_d       = streak_q;
    to_cnt_d       = to_cnt_q;
    run_first_d    = 1'b0;
    host_ack_d     = 1'b0;
    host_done_d    = 1'b0;
    pr_ack_d       = 1'b0;
    process_iseq_d = 1'b0;
    lock_d         = 1'b0;
    pr_timeout_d   = pr_timeout;

    unique case (state_q)
      IDLE: begin
        // armed_q holds off any grant on the first edge after reset release.
        if (armed_q) begin
          if (pr_req && (!host_req || (streak_q < STREAK_MAX))) begin
            state_d  = PR_LOCK;
            lock_d   = 1'b1;
            to_cnt_d = '0;
            if (host_req && (streak_q < STREAK_MAX)) begin
              streak_d = streak_q + 1'b1;
            end
          end else if (host_req) begin
            state_d        = HOST_START;
            process_iseq_d = 1'b1;
            host_ack_d     = 1'b1;
            streak_d       = '0;
          end
        end
      end

      HOST_START: begin
        state_d     = HOST_RUN;
        run_first_d = 1'b1;
      end

      HOST_RUN: begin
        if (!run_first_q && !dispatcher_busy) begin
          state_d     = IDLE;
          host_done_d = 1'b1;
        end
      end

      PR_LOCK: begin
        if (pr_rd_ack) begin
          state_d  = IDLE;
          pr_ack_d = 1'b1;
        end else if (to_cnt_q == TO_LIMIT) begin
          state_d      = IDLE;
          pr_timeout_d = 1'b1;
        end else begin
          lock_d   = 1'b1;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      streak_q           <= '0;
      to_cnt_q           <= '0;
      run_first_q        <= 1'b0;
      armed_q            <= 1'b0;
      host_ack           <= 1'b0;
      host_done          <= 1'b0;
      pr_ack             <= 1'b0;
      process_iseq       <= 1'b0;
      periodic_read_lock <= 1'b0;
      pr_timeout         <= 1'b0;
    end else begin
      state_q            <= state_d;
      streak_q           <= streak_d;
      to_cnt_q           <= to_cnt_d;
      run_first_q        <= run_first_d;
      armed_q            <= 1'b1;
      host_ack           <= host_ack_d;
      host_done          <= host_done_d;
      pr_ack             <= pr_ack_d;
      process_iseq       <= process_iseq_d;
      periodic_read_lock <= lock_d;
      pr_timeout         <= pr_timeout_d;
    end
  end

  assign arb_state = state_q;

endmodule
